// File: rtl/tx_relatorio_peso_8n1_pkg.sv
// Shared definitions for the weight-report transmitter.
// Holds the ASCII constants used in the report, the state encoding visible on
// db_estado, the default bit period and the digit-to-ASCII helper.
package tx_relatorio_peso_8n1_pkg;

  localparam int unsigned CLKS_PER_BIT_PADRAO = 434;  // 50 MHz / 115200 baud

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_UM   = 8'h31;
  localparam logic [7:0] ASCII_ERRO = 8'h3F;
  localparam logic [7:0] ASCII_HASH = 8'h23;

  // Code 7 is deliberately unused; every FSM maps it back to StOcioso.
  typedef enum logic [2:0] {
    StOcioso  = 3'd0,
    StCarrega = 3'd1,
    StStart   = 3'd2,
    StDados   = 3'd3,
    StStop    = 3'd4,
    StProximo = 3'd5,
    StFim     = 3'd6
  } estado_e;

  // Binary digit to ASCII; anything above 9 becomes '?' rather than ':'..
  function automatic logic [7:0] digito_ascii(input logic [7:0] digito);
    return (digito > 8'd9) ? ASCII_ERRO : (ASCII_ZERO + digito);
  endfunction

endpackage

// File: rtl/tx_relatorio_peso_8n1_if.sv
// Handshake and data bundle between the control unit and the report
// transmitter.
//   partida            : request one report (control unit -> transmitter)
//   peso_atual[15:8]   : tens digit, binary 0..9
//   peso_atual[7:0]    : units digit, binary 0..9
//   pertence_intervalo : in-range flag to report
//   ocupado            : transmitter busy (transmitter -> control unit)
//   pronto             : one-cycle end-of-report pulse
interface tx_relatorio_peso_8n1_if;

  logic        partida;
  logic [15:0] peso_atual;
  logic        pertence_intervalo;
  logic        ocupado;
  logic        pronto;

  modport master (
    output partida,
    output peso_atual,
    output pertence_intervalo,
    input  ocupado,
    input  pronto
  );

  modport slave (
    input  partida,
    input  peso_atual,
    input  pertence_intervalo,
    output ocupado,
    output pronto
  );

endinterface

// File: rtl/tx_relatorio_peso_8n1_tx_serial_8n1.sv
// Single-byte 8N1 serializer: start bit, 8 data bits LSB first, stop bit,
// each held exactly CLKS_PER_BIT clocks.
//   clock, reset : system clock, synchronous active-low reset
//   i_inicio     : load i_dado and start a frame (accepted only when idle)
//   i_dado       : byte to send
//   o_serial     : line level for the current bit (idle high)
//   o_ativo      : a frame is in progress
//   o_fim        : high in the last clock of the stop bit
//   o_estado     : current phase (StOcioso/StStart/StDados/StStop)
module tx_relatorio_peso_8n1_tx_serial_8n1
  import tx_relatorio_peso_8n1_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_inicio,
  input  logic [7:0] i_dado,
  output logic       o_serial,
  output logic       o_ativo,
  output logic       o_fim,
  output estado_e    o_estado
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntUltimo = CntW'(CLKS_PER_BIT - 1);

  estado_e         estado_q, estado_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      desloc_q, desloc_d;
  logic            ultimo;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= StOcioso;
      cnt_q    <= '0;
      bit_q    <= '0;
      desloc_q <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      desloc_q <= desloc_d;
    end
  end

  assign ultimo = (cnt_q == CntUltimo);

  // The baud counter is cleared on every phase change so each bit spans
  // exactly CLKS_PER_BIT clocks.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q + CntW'(1);
    bit_d    = bit_q;
    desloc_d = desloc_q;
    o_fim    = 1'b0;
    case (estado_q)
      StOcioso: begin
        cnt_d = '0;
        if (i_inicio) begin
          desloc_d = i_dado;
          bit_d    = '0;
          estado_d = StStart;
        end
      end
      StStart: begin
        if (ultimo) begin
          cnt_d    = '0;
          estado_d = StDados;
        end
      end
      StDados: begin
        if (ultimo) begin
          cnt_d    = '0;
          desloc_d = {1'b0, desloc_q[7:1]};
          bit_d    = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            estado_d = StStop;
          end
        end
      end
      StStop: begin
        if (ultimo) begin
          cnt_d    = '0;
          estado_d = StOcioso;
          o_fim    = 1'b1;
        end
      end
      default: begin
        cnt_d    = '0;
        estado_d = StOcioso;
      end
    endcase
  end

  always_comb begin
    case (estado_q)
      StStart: o_serial = 1'b0;
      StDados: o_serial = desloc_q[0];
      default: o_serial = 1'b1;
    endcase
  end

  assign o_ativo  = (estado_q != StOcioso);
  assign o_estado = estado_q;

endmodule

// File: rtl/tx_relatorio_peso_8n1.sv
// Weight status report transmitter: on partida, latches a 4-byte ASCII report
// (tens digit, units digit, in-range flag, terminator) and sends it over 8N1.
//   clock, reset : system clock, synchronous active-low reset
//   ctrl         : control-unit handshake (partida, peso_atual,
//                  pertence_intervalo in; ocupado, pronto out)
//   saida_serial : 8N1 line, idle high
//   db_estado    : state code for debug (0..6)
// Every output is a flop fed from the current state, so all outputs trail the
// state register by one clock and stay mutually aligned.
module tx_relatorio_peso_8n1
  import tx_relatorio_peso_8n1_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_PADRAO,
  parameter logic [7:0]  TERMINADOR   = ASCII_HASH
) (
  input  logic                    clock,
  input  logic                    reset,
  tx_relatorio_peso_8n1_if.slave  ctrl,
  output logic                    saida_serial,
  output logic [2:0]              db_estado
);

  estado_e         estado_q, estado_d;
  logic [1:0]      indice_q, indice_d;
  logic [3:0][7:0] buffer_q, buffer_d;

  logic            linha_q, linha_d;
  logic            ocupado_q, ocupado_d;
  logic            pronto_q, pronto_d;
  logic [2:0]      db_q, db_d;

  logic            inicio;
  logic            ser_serial;
  logic            ser_ativo;
  logic            ser_fim;
  estado_e         ser_estado;

  tx_relatorio_peso_8n1_tx_serial_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serial (
    .clock   (clock),
    .reset   (reset),
    .i_inicio(inicio),
    .i_dado  (buffer_q[indice_q]),
    .o_serial(ser_serial),
    .o_ativo (ser_ativo),
    .o_fim   (ser_fim),
    .o_estado(ser_estado)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q  <= StOcioso;
      indice_q  <= '0;
      buffer_q  <= '0;
      linha_q   <= 1'b1;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      db_q      <= 3'(StOcioso);
    end else begin
      estado_q  <= estado_d;
      indice_q  <= indice_d;
      buffer_q  <= buffer_d;
      linha_q   <= linha_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
      db_q      <= db_d;
    end
  end

  // Sequencer. While the serializer runs, this FSM parks in StStart and
  // waits for the end of the stop bit.
  always_comb begin
    estado_d = estado_q;
    indice_d = indice_q;
    buffer_d = buffer_q;
    inicio   = 1'b0;
    case (estado_q)
      StOcioso: begin
        if (ctrl.partida) begin
          buffer_d = {TERMINADOR,
                      ctrl.pertence_intervalo ? ASCII_UM : ASCII_ZERO,
                      digito_ascii(ctrl.peso_atual[7:0]),
                      digito_ascii(ctrl.peso_atual[15:8])};
          indice_d = '0;
          estado_d = StCarrega;
        end
      end
      StCarrega: begin
        inicio   = 1'b1;
        estado_d = StStart;
      end
      StStart: begin
        if (ser_fim) begin
          estado_d = (indice_q == 2'd3) ? StFim : StProximo;
        end
      end
      StProximo: begin
        indice_d = indice_q + 2'd1;
        estado_d = StCarrega;
      end
      StFim: begin
        estado_d = StOcioso;
      end
      default: begin
        estado_d = StOcioso;
      end
    endcase
  end

  always_comb begin
    linha_d   = ser_serial;
    ocupado_d = (estado_q == StCarrega) || (estado_q == StStart) ||
                (estado_q == StProximo);
    pronto_d  = (estado_q == StFim);
    db_d      = ser_ativo ? 3'(ser_estado) : 3'(estado_q);
  end

  assign saida_serial = linha_q;
  assign db_estado    = db_q;
  assign ctrl.ocupado = ocupado_q;
  assign ctrl.pronto  = pronto_q;

endmodule

// File: tb/tb_tx_relatorio_peso_8n1.sv
// Bench for tx_relatorio_peso_8n1: four instances (bit periods 4, 2, 5, 434)
// checked cycle by cycle against a waveform model of the report.
module tb_tx_relatorio_peso_8n1;

  typedef struct packed {
    logic [15:0] peso;
    logic        pert;
    logic [31:0] esp;  // byte0 in [7:0] .. byte3 in [31:24]
  } vetor_t;

  logic             clock;
  logic             reset;
  logic [3:0]       partida_v;
  logic [15:0]      peso;
  logic             pert;
  logic [3:0]       linha_v;
  logic [3:0]       ocup_v;
  logic [3:0]       pronto_v;
  logic [3:0][2:0]  db_v;

  int n_vec;
  int n_err;

  tx_relatorio_peso_8n1_if if0 ();
  tx_relatorio_peso_8n1_if if1 ();
  tx_relatorio_peso_8n1_if if2 ();
  tx_relatorio_peso_8n1_if if3 ();

  assign if0.partida = partida_v[0];
  assign if1.partida = partida_v[1];
  assign if2.partida = partida_v[2];
  assign if3.partida = partida_v[3];
  assign if0.peso_atual = peso;
  assign if1.peso_atual = peso;
  assign if2.peso_atual = peso;
  assign if3.peso_atual = peso;
  assign if0.pertence_intervalo = pert;
  assign if1.pertence_intervalo = pert;
  assign if2.pertence_intervalo = pert;
  assign if3.pertence_intervalo = pert;
  assign ocup_v   = {if3.ocupado, if2.ocupado, if1.ocupado, if0.ocupado};
  assign pronto_v = {if3.pronto, if2.pronto, if1.pronto, if0.pronto};

  tx_relatorio_peso_8n1 #(.CLKS_PER_BIT(4)) dut0 (
    .clock(clock), .reset(reset), .ctrl(if0),
    .saida_serial(linha_v[0]), .db_estado(db_v[0]));
  tx_relatorio_peso_8n1 #(.CLKS_PER_BIT(2)) dut1 (
    .clock(clock), .reset(reset), .ctrl(if1),
    .saida_serial(linha_v[1]), .db_estado(db_v[1]));
  tx_relatorio_peso_8n1 #(.CLKS_PER_BIT(5)) dut2 (
    .clock(clock), .reset(reset), .ctrl(if2),
    .saida_serial(linha_v[2]), .db_estado(db_v[2]));
  tx_relatorio_peso_8n1 #(.CLKS_PER_BIT(434)) dut3 (
    .clock(clock), .reset(reset), .ctrl(if3),
    .saida_serial(linha_v[3]), .db_estado(db_v[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cmp(input string nome, input logic [31:0] atual, input logic [31:0] req);
    n_vec++;
    if (atual !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, req);
    end
  endtask

  // Expected outputs i clocks after the clock in which partida was taken.
  // Timeline: 1 load cycle, then per byte 10*c bit cycles, 2-cycle gap
  // between bytes, then one pronto cycle.
  function automatic void esperado(input int i, input int c, input logic [31:0] esp,
                                   output logic el, output logic eo, output logic ep);
    int per, p, j, r, b;
    el = 1'b1; eo = 1'b0; ep = 1'b0;
    per = 10 * c + 2;
    if (i == 0) begin
      eo = 1'b1;
      return;
    end
    p = i - 1;
    j = p / per;
    r = p % per;
    if (j > 3) return;
    if (r >= 10 * c) begin
      if (j < 3) eo = 1'b1;
      else if (r == 10 * c) ep = 1'b1;
      return;
    end
    eo = 1'b1;
    b = r / c;
    if (b == 0) el = 1'b0;
    else if (b <= 8) el = esp[j*8+b-1];
  endfunction

  // Runs one report on instance s. Caller has partida high for the next
  // edge. k_pert >= 1 re-pulses partida and zeroes the inputs mid-report.
  task automatic relatorio(input int s, input int c, input logic [31:0] esp, input bit segura,
                           input int k_pert, input string nome);
    int n, err_l, err_o, err_p, pri_l, pri_o, pri_p, k;
    logic el, eo, ep;
    logic cap[];
    logic [7:0] byte_rx;
    n = 40 * c + 8;
    cap = new[n + 1];
    err_l = 0; err_o = 0; err_p = 0; pri_l = 0; pri_o = 0; pri_p = 0;
    tick();
    if (!segura) partida_v[s] = 1'b0;
    for (int kk = 1; kk <= n; kk++) begin
      tick();
      if (kk == k_pert) begin
        peso = 16'h0000; pert = 1'b0; partida_v[s] = 1'b1;
      end else if (kk == k_pert + 1 && !segura) begin
        partida_v[s] = 1'b0;
      end
      esperado(kk - 1, c, esp, el, eo, ep);
      cap[kk] = linha_v[s];
      if (linha_v[s] !== el) begin if (err_l == 0) pri_l = kk; err_l++; end
      if (ocup_v[s] !== eo) begin if (err_o == 0) pri_o = kk; err_o++; end
      if (pronto_v[s] !== ep) begin if (err_p == 0) pri_p = kk; err_p++; end
    end
    cmp($sformatf("%s saida_serial bad cycles (first at %0d)", nome, pri_l), err_l, 0);
    cmp($sformatf("%s ocupado bad cycles (first at %0d)", nome, pri_o), err_o, 0);
    cmp($sformatf("%s pronto bad cycles (first at %0d)", nome, pri_p), err_p, 0);
    for (int j = 0; j < 4; j++) begin
      for (int b = 0; b < 8; b++) begin
        k = 2 + j * (10 * c + 2) + (1 + b) * c + c / 2;
        byte_rx[b] = cap[k];
      end
      cmp($sformatf("%s byte%0d", nome, j), {24'h0, byte_rx}, {24'h0, esp[j*8 +: 8]});
    end
  endtask

  task automatic silencio(input int s, input int ciclos, input string nome);
    int err;
    err = 0;
    for (int i = 0; i < ciclos; i++) begin
      tick();
      if (linha_v[s] !== 1'b1 || ocup_v[s] !== 1'b0 || pronto_v[s] !== 1'b0) err++;
    end
    cmp($sformatf("%s idle violations", nome), err, 0);
  endtask

  vetor_t tabela[6];

  initial begin
    n_vec = 0;
    n_err = 0;
    tabela[0] = '{16'h0307, 1'b1, 32'h2331_3733};
    tabela[1] = '{16'h0A09, 1'b0, 32'h2330_393F};
    tabela[2] = '{16'h0000, 1'b0, 32'h2330_3030};
    tabela[3] = '{16'h0900, 1'b1, 32'h2331_3039};
    tabela[4] = '{16'hFF0B, 1'b1, 32'h2331_3F3F};
    tabela[5] = '{16'h0509, 1'b0, 32'h2330_3935};

    reset = 1'b0;
    partida_v = '0;
    peso = '0;
    pert = 1'b0;
    repeat (3) tick();
    for (int s = 0; s < 4; s++) begin
      cmp($sformatf("reset saida_serial dut%0d", s), {31'h0, linha_v[s]}, 1);
      cmp($sformatf("reset ocupado dut%0d", s), {31'h0, ocup_v[s]}, 0);
      cmp($sformatf("reset pronto dut%0d", s), {31'h0, pronto_v[s]}, 0);
      cmp($sformatf("reset db_estado dut%0d", s), {29'h0, db_v[s]}, 0);
    end
    reset = 1'b1;
    tick();

    // Table of reports on the 4-clock instance
    for (int v = 0; v < 6; v++) begin
      peso = tabela[v].peso;
      pert = tabela[v].pert;
      partida_v[0] = 1'b1;
      relatorio(0, 4, tabela[v].esp, 1'b0, -1, $sformatf("vec%0d", v));
    end

    // New inputs and partida during byte1 must not disturb the report
    peso = 16'h0A09; pert = 1'b0;
    partida_v[0] = 1'b1;
    relatorio(0, 4, 32'h2330_393F, 1'b0, 63, "busy_partida");
    silencio(0, 60, "after busy_partida");

    // Reset during DADOS of byte2
    peso = 16'h0408; pert = 1'b1;
    partida_v[0] = 1'b1;
    tick();
    partida_v[0] = 1'b0;
    repeat (95) tick();
    cmp("db_estado in DADOS", {29'h0, db_v[0]}, 3);
    cmp("ocupado in DADOS", {31'h0, ocup_v[0]}, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cmp("mid-reset saida_serial", {31'h0, linha_v[0]}, 1);
    cmp("mid-reset ocupado", {31'h0, ocup_v[0]}, 0);
    cmp("mid-reset pronto", {31'h0, pronto_v[0]}, 0);
    cmp("mid-reset db_estado", {29'h0, db_v[0]}, 0);
    silencio(0, 200, "after mid-reset");
    partida_v[0] = 1'b1;
    relatorio(0, 4, 32'h2331_3834, 1'b0, -1, "post_reset");

    // Back-to-back reports with partida held high
    peso = 16'h0605; pert = 1'b0;
    partida_v[0] = 1'b1;
    relatorio(0, 4, 32'h2330_3536, 1'b1, -1, "b2b_first");
    relatorio(0, 4, 32'h2330_3536, 1'b1, -1, "b2b_second");
    partida_v[0] = 1'b0;
    silencio(0, 60, "after b2b");

    // Bit-period sweep
    peso = 16'h0307; pert = 1'b1;
    partida_v[1] = 1'b1;
    relatorio(1, 2, 32'h2331_3733, 1'b0, -1, "clks2");
    partida_v[2] = 1'b1;
    relatorio(2, 5, 32'h2331_3733, 1'b0, -1, "clks5");
    partida_v[3] = 1'b1;
    relatorio(3, 434, 32'h2331_3733, 1'b0, -1, "clks434");
    silencio(3, 20, "after clks434");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
